// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// cause codes, mstatus/mie bit positions and the sequencer state encoding.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_MEI     = 4'd11;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MSIE       = 3;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_R_MSTATUS = 3'd4,
    ST_JUMP      = 3'd5
  } state_e;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Interrupt qualification and trap priority encoder (purely combinational).
// Priority: ext > sft > tmr > ecall > ebreak; interrupts need mstatus.MIE.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic       ext_irq_i,
  input  logic       sft_irq_i,
  input  logic       tmr_irq_i,
  input  logic       ecall_i,
  input  logic       ebreak_i,
  input  logic       mstatus_mie_i,
  input  logic       meie_i,
  input  logic       msie_i,
  input  logic       mtie_i,
  output logic       valid_o,
  output logic       is_irq_o,
  output logic [3:0] code_o
);

  logic irq_ext;
  logic irq_sft;
  logic irq_tmr;

  // NOTE: every output gets a default first so no path through the if-chain
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    irq_ext  = ext_irq_i & meie_i & mstatus_mie_i;
    irq_sft  = sft_irq_i & msie_i & mstatus_mie_i;
    irq_tmr  = tmr_irq_i & mtie_i & mstatus_mie_i;
    valid_o  = 1'b0;
    is_irq_o = 1'b0;
    code_o   = 4'd0;
    if (irq_ext) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      code_o   = CAUSE_MEI;
    end else if (irq_sft) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      code_o   = CAUSE_MSI;
    end else if (irq_tmr) begin
      valid_o  = 1'b1;
      is_irq_o = 1'b1;
      code_o   = CAUSE_MTI;
    end else if (ecall_i) begin
      valid_o  = 1'b1;
      code_o   = CAUSE_ECALL_M;
    end else if (ebreak_i) begin
      valid_o  = 1'b1;
      code_o   = CAUSE_BREAK;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts interrupts/ecall/ebreak/mret in IDLE,
// stalls the pipeline, writes mepc/mcause/mstatus one per cycle, then redirects.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ext_irq_i,
  input  logic          sft_irq_i,
  input  logic          tmr_irq_i,
  input  logic          ecall_i,
  input  logic          ebreak_i,
  input  logic          mret_i,
  input  logic [DW-1:0] pc_i,
  input  logic [DW-1:0] csr_mstatus_i,
  input  logic [DW-1:0] csr_mie_i,
  input  logic [DW-1:0] csr_mtvec_i,
  input  logic [DW-1:0] csr_mepc_i,
  output logic          clt_we_o,
  output logic [11:0]   clt_addr_o,
  output logic [DW-1:0] clt_data_o,
  output logic          hold_o,
  output logic          jump_en_o,
  output logic [DW-1:0] jump_addr_o
);

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] cause_q, cause_d;
  logic [DW-1:0] target_q, target_d;

  logic          trap_valid;
  logic          trap_is_irq;
  logic [3:0]    trap_code;
  logic          accept_trap;
  logic          accept_mret;
  logic [DW-1:0] vec_base;
  logic [DW-1:0] trap_target;
  logic [DW-1:0] trap_cause;
  logic [DW-1:0] mstatus_entry;
  logic [DW-1:0] mstatus_mret;
  logic          unused_mie;

  trap_prio u_prio (
    .ext_irq_i     (ext_irq_i),
    .sft_irq_i     (sft_irq_i),
    .tmr_irq_i     (tmr_irq_i),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .mstatus_mie_i (csr_mstatus_i[MSTATUS_MIE]),
    .meie_i        (csr_mie_i[MIE_MEIE]),
    .msie_i        (csr_mie_i[MIE_MSIE]),
    .mtie_i        (csr_mie_i[MIE_MTIE]),
    .valid_o       (trap_valid),
    .is_irq_o      (trap_is_irq),
    .code_o        (trap_code)
  );

  assign unused_mie = ^csr_mie_i;

  always_comb begin
    vec_base = {csr_mtvec_i[DW-1:2], 2'b00};
    // Only interrupts are vectored; mode values 2 and 3 fall back to direct.
    if (trap_is_irq && csr_mtvec_i[1:0] == 2'b01) begin
      trap_target = vec_base + {{(DW-6){1'b0}}, trap_code, 2'b00};
    end else begin
      trap_target = vec_base;
    end
    trap_cause         = '0;
    trap_cause[DW-1]   = trap_is_irq;
    trap_cause[3:0]    = trap_code;

    mstatus_entry                                = csr_mstatus_i;
    mstatus_entry[MSTATUS_MPIE]                  = csr_mstatus_i[MSTATUS_MIE];
    mstatus_entry[MSTATUS_MIE]                   = 1'b0;
    mstatus_entry[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mstatus_mret                                 = csr_mstatus_i;
    mstatus_mret[MSTATUS_MIE]                    = csr_mstatus_i[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE]                   = 1'b1;
    mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

  // Events are only accepted out of reset and in IDLE; a trap shadows mret.
  assign accept_trap = rst_n & (state_q == ST_IDLE) & trap_valid;
  assign accept_mret = rst_n & (state_q == ST_IDLE) & ~trap_valid & mret_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    target_d    = target_q;
    clt_we_o    = 1'b0;
    clt_addr_o  = 12'h000;
    clt_data_o  = '0;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    hold_o      = accept_trap | accept_mret | (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (accept_trap) begin
          pc_d     = pc_i;
          cause_d  = trap_cause;
          target_d = trap_target;
          state_d  = ST_W_MEPC;
        end else if (accept_mret) begin
          target_d = csr_mepc_i;
          state_d  = ST_R_MSTATUS;
        end
      end
      ST_W_MEPC: begin
        clt_we_o   = 1'b1;
        clt_addr_o = CSR_MEPC;
        clt_data_o = pc_q;
        state_d    = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        clt_we_o   = 1'b1;
        clt_addr_o = CSR_MCAUSE;
        clt_data_o = cause_q;
        state_d    = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        clt_we_o   = 1'b1;
        clt_addr_o = CSR_MSTATUS;
        clt_data_o = mstatus_entry;
        state_d    = ST_JUMP;
      end
      ST_R_MSTATUS: begin
        clt_we_o   = 1'b1;
        clt_addr_o = CSR_MSTATUS;
        clt_data_o = mstatus_mret;
        state_d    = ST_JUMP;
      end
      ST_JUMP: begin
        jump_en_o   = 1'b1;
        jump_addr_o = target_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR writes / jumps
// with their cycle; a negedge monitor pops and compares whatever the DUT emits.
module tb_trap_ctrl;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ext_irq_i, sft_irq_i, tmr_irq_i;
  logic          ecall_i, ebreak_i, mret_i;
  logic [DW-1:0] pc_i, csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
  logic          clt_we_o;
  logic [11:0]   clt_addr_o;
  logic [DW-1:0] clt_data_o;
  logic          hold_o;
  logic          jump_en_o;
  logic [DW-1:0] jump_addr_o;

  typedef struct {
    bit          is_jump;
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  trap_ctrl #(.DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ext_irq_i     (ext_irq_i),
    .sft_irq_i     (sft_irq_i),
    .tmr_irq_i     (tmr_irq_i),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .mret_i        (mret_i),
    .pc_i          (pc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_mie_i     (csr_mie_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .clt_we_o      (clt_we_o),
    .clt_addr_o    (clt_addr_o),
    .clt_data_o    (clt_data_o),
    .hold_o        (hold_o),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [63:0] d, input int c);
    exp_t e;
    e.is_jump = 1'b0; e.addr = a; e.data = d; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic push_jmp(input logic [63:0] d, input int c);
    exp_t e;
    e.is_jump = 1'b1; e.addr = 12'h000; e.data = d; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic clear_events();
    ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0;
    ecall_i = 0; ebreak_i = 0; mret_i = 0;
  endtask

  // Monitor: pops one expectation per emitted write or jump.
  always @(negedge clk) begin
    if (mon_en) begin
      if (clt_we_o || jump_en_o) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got we=%0b jump=%0b addr=0x%h data=0x%h jaddr=0x%h, expected none (cycle %0d)",
                   clt_we_o, jump_en_o, clt_addr_o, clt_data_o, jump_addr_o, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("jump_en", {63'd0, jump_en_o}, {63'd0, mon_e.is_jump});
          check("csr_we", {63'd0, clt_we_o}, {63'd0, !mon_e.is_jump});
          if (mon_e.is_jump) begin
            check("jump_addr", jump_addr_o, mon_e.data);
            check("addr_in_jump", {52'd0, clt_addr_o}, 64'd0);
          end else begin
            check("csr_addr", {52'd0, clt_addr_o}, {52'd0, mon_e.addr});
            check("csr_data", clt_data_o, mon_e.data);
            check("jaddr_in_write", jump_addr_o, 64'd0);
          end
        end
      end else begin
        check("idle_outputs_zero", {clt_addr_o, 52'd0} | clt_data_o | jump_addr_o, 64'd0);
      end
    end
  end

  // Caller drives the event just after a rising edge; that cycle is N.
  task automatic run_trap(input string nm, input logic [63:0] e_pc, input logic [63:0] e_cause,
                          input logic [63:0] e_ms, input logic [63:0] e_tgt);
    int n;
    n = cyc;
    #1 check({nm, "_hold_N"}, {63'd0, hold_o}, 64'd1);
    push_wr(12'h341, e_pc, n + 1);
    push_wr(12'h342, e_cause, n + 2);
    push_wr(12'h300, e_ms, n + 3);
    push_jmp(e_tgt, n + 4);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_events();
      #1 check({nm, "_hold_seq"}, {63'd0, hold_o}, 64'd1);
    end
    @(posedge clk); #2;
    check({nm, "_hold_done"}, {63'd0, hold_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    clear_events();
    pc_i = 0; csr_mstatus_i = 0; csr_mie_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {63'd0, hold_o}, 64'd0);
    check("rst_we_jump", {62'd0, clt_we_o, jump_en_o}, 64'd0);
    check("rst_data", clt_data_o | jump_addr_o | {52'd0, clt_addr_o}, 64'd0);
    rst_n = 1;
    mon_en = 1;

    // Timer interrupt, direct vector.
    @(posedge clk); #1;
    csr_mstatus_i = 64'h8; csr_mie_i = 64'h80; csr_mtvec_i = 64'h8000_0000;
    pc_i = 64'h1000; tmr_irq_i = 1;
    run_trap("tmr_direct", 64'h1000, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_0000);

    // External wins over software and a simultaneous ecall; vectored.
    @(posedge clk); #1;
    csr_mstatus_i = 64'h8; csr_mie_i = 64'h888; csr_mtvec_i = 64'h8000_0001;
    pc_i = 64'h1100; ext_irq_i = 1; sft_irq_i = 1; ecall_i = 1;
    run_trap("ext_vec", 64'h1100, 64'h8000_0000_0000_000B, 64'h1880, 64'h8000_002C);

    // Software interrupt, vectored.
    @(posedge clk); #1;
    csr_mstatus_i = 64'h8; csr_mie_i = 64'h8; csr_mtvec_i = 64'h0100_0001;
    pc_i = 64'h1200; sft_irq_i = 1;
    run_trap("sft_vec", 64'h1200, 64'h8000_0000_0000_0003, 64'h1880, 64'h0100_000C);

    // ecall with MIE=0 and a timer pending: exception uses base even if vectored.
    @(posedge clk); #1;
    csr_mstatus_i = 64'h0; csr_mie_i = 64'h80; csr_mtvec_i = 64'h8000_0001;
    pc_i = 64'h2000; tmr_irq_i = 1; ecall_i = 1;
    run_trap("ecall_mie0", 64'h2000, 64'd11, 64'h1800, 64'h8000_0000);

    // ebreak with mtvec mode 3 (direct), mstatus upper bits preserved.
    @(posedge clk); #1;
    csr_mstatus_i = 64'hA000_0000_0000_0008; csr_mie_i = 64'h0; csr_mtvec_i = 64'h4000_0003;
    pc_i = 64'h2400; ebreak_i = 1;
    run_trap("ebreak_mode3", 64'h2400, 64'd3, 64'hA000_0000_0000_1880, 64'h4000_0000);

    // Pending timer masked by mie: no event.
    @(posedge clk); #1;
    csr_mstatus_i = 64'h8; csr_mie_i = 64'h0; tmr_irq_i = 1;
    #1 check("masked_irq_hold", {63'd0, hold_o}, 64'd0);
    @(posedge clk); #2;
    check("masked_irq_hold2", {63'd0, hold_o}, 64'd0);
    clear_events();

    // mret.
    @(posedge clk); #1;
    begin
      int n;
      n = cyc;
      csr_mstatus_i = 64'h1880; csr_mepc_i = 64'h3004; mret_i = 1;
      #1 check("mret_hold_N", {63'd0, hold_o}, 64'd1);
      push_wr(12'h300, 64'h1888, n + 1);
      push_jmp(64'h3004, n + 2);
      @(posedge clk); #1; clear_events();
      #1 check("mret_hold_N1", {63'd0, hold_o}, 64'd1);
      @(posedge clk); #2;
      check("mret_hold_N2", {63'd0, hold_o}, 64'd1);
      @(posedge clk); #2;
      check("mret_hold_N3", {63'd0, hold_o}, 64'd0);
    end

    // Reset asserted during W_MCAUSE aborts the sequence.
    @(posedge clk); #1;
    begin
      int n;
      n = cyc;
      csr_mstatus_i = 64'h8; csr_mie_i = 64'h80; csr_mtvec_i = 64'h8000_0000;
      pc_i = 64'h1000; tmr_irq_i = 1;
      push_wr(12'h341, 64'h1000, n + 1);
      push_wr(12'h342, 64'h8000_0000_0000_0007, n + 2);
      @(posedge clk); #1; clear_events();
      @(posedge clk); #1; rst_n = 0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #2;
        check("rstmid_hold", {63'd0, hold_o}, 64'd0);
        check("rstmid_we_jump", {62'd0, clt_we_o, jump_en_o}, 64'd0);
        check("rstmid_data", clt_data_o | jump_addr_o | {52'd0, clt_addr_o}, 64'd0);
      end
      rst_n = 1;
      repeat (4) @(posedge clk);
      #2 check("rstmid_hold_after", {63'd0, hold_o}, 64'd0);
    end

    repeat (3) @(posedge clk);
    #2 check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller for the pipeline CPU, sitting directly upstream of the CSR register file on its `clt_*` write port. It detects enabled interrupts (external, software, timer), `ecall`/`ebreak` and `mret`, then holds the pipeline. It sequences the CSR updates (mepc, mcause, mstatus) one per cycle and finally issues a redirect to the trap vector or to mepc.

## Interface
Parameters
- `DW`, 64: data/address width (`DATA_WIDTH`).

Ports
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `ext_irq_i` / `sft_irq_i` / `tmr_irq_i`  in  1 each  level-sensitive interrupt requests.
- `ecall_i` / `ebreak_i` / `mret_i`  in  1 each  decoded from the instruction in EX, one-cycle pulses.
- `pc_i`  in  DW  PC of the instruction currently in EX.
- `csr_mstatus_i` / `csr_mie_i` / `csr_mtvec_i` / `csr_mepc_i`  in  DW each  live values from the CSR file.
- `clt_we_o`  out  1  CSR write enable.
- `clt_addr_o`  out  12  CSR address (`BUS_CSR_IMM`).
- `clt_data_o`  out  DW  CSR write data.
- `hold_o`  out  1  pipeline stall request; EX must not assert `ex_we` while this is high.
- `jump_en_o`  out  1  one-cycle redirect strobe.
- `jump_addr_o`  out  DW  redirect target.

## Operation
- **Interrupt qualification**
  - Global enable: mstatus.MIE (bit 3).
  - `irq_ext = ext_irq_i & mie[11]`
  - `irq_sft = sft_irq_i & mie[3]`
  - `irq_tmr = tmr_irq_i & mie[7]`
  - Priority: ext > sft > tmr.
- **Event priority (IDLE only):** enabled interrupt > ecall > ebreak > mret. Lower-priority events in the same cycle are dropped. Software must re-execute them; since mepc = `pc_i`, that happens naturally.
- **mcause values**
  - ext: `{1'b1, 63'd11}`
  - sft: `{1'b1, 63'd3}`
  - tmr: `{1'b1, 63'd7}`
  - ecall: 11
  - ebreak: 3
- **Trap target**
  - base = `{mtvec[DW-1:2], 2'b00}`.
  - mtvec[1:0] = 0 (direct): target = base.
  - mtvec[1:0] = 1 (vectored) and the trap is an interrupt: target = base + 4·code, using a DW-bit add with wrap ignored.
  - Exceptions always use base.
  - mtvec[1:0] ≥ 2: treated as direct.
- **mstatus on trap entry:** MPIE(7) ← MIE(3); MIE ← 0; MPP[12:11] ← 2'b11. All other bits are preserved from `csr_mstatus_i`.
- **mstatus on mret:** MIE ← MPIE; MPIE ← 1; MPP ← 2'b11; other bits preserved.
- **FSM states:** IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP.
  - Trap path: IDLE → W_MEPC → W_MCAUSE → W_MSTATUS → JUMP → IDLE.
  - mret path: IDLE → R_MSTATUS → JUMP → IDLE.
- **Latched on event acceptance:** `pc_i`, cause, and target. For a trap the target is the computed vector; for mret it is `csr_mepc_i`.
- **During a sequence:** new events and interrupt changes are ignored. Level interrupts remain pending and are re-evaluated in IDLE.
- **Writes per state** (each state has `clt_we_o`=1 with the listed address and data):
  - W_MEPC: `CSR_MEPC`, latched pc.
  - W_MCAUSE: `CSR_MCAUSE`, latched cause.
  - W_MSTATUS / R_MSTATUS: `CSR_MSTATUS`, modified `csr_mstatus_i`.
  - In all other states `clt_we_o`=0, `clt_addr_o`=0, `clt_data_o`=0.

## Timing
- **Reset:** at the first edge with `rst_n`=0, state ← IDLE and all latches clear. All outputs are 0 in the following cycle. A reset mid-sequence aborts it; no further CSR writes and no jump occur.
- **Trap sequence** (event accepted at cycle N):
  - N: `hold_o`=1, combinational from the event detect.
  - N+1: mepc write.
  - N+2: mcause write.
  - N+3: mstatus write.
  - N+4: `jump_en_o`=1 with the target.
  - N+5: IDLE; `hold_o` drops.
- **mret sequence** (accepted at N): N+1 mstatus write, N+2 jump, N+3 IDLE.
- `hold_o` is high from N through the JUMP cycle inclusive.
- `jump_en_o` is exactly one cycle wide. `jump_addr_o` is 0 when `jump_en_o`=0.
- **Back-to-back:** an interrupt still enabled in the IDLE cycle after a sequence starts a new sequence that cycle. After trap entry MIE=0, so a trap cannot chain.

## Structure
- Add to `define.v`:
  - cause codes `CAUSE_MEI`, `CAUSE_MSI`, `CAUSE_MTI`, `CAUSE_ECALL_M`, `CAUSE_BREAK`;
  - mstatus/mie bit positions (`MSTATUS_MIE`, `MSTATUS_MPIE`, `MSTATUS_MPP`, `MIE_MEIE`, `MIE_MSIE`, `MIE_MTIE`);
  - FSM state encodings.
- The existing `CSR_*` address macros are reused.
- One combinational sub-module, `trap_prio`, holds interrupt qualification plus the priority encoder. It outputs `valid`, `is_irq` and `code[3:0]`.
- Latches use `gnrl_dff`.

## Test plan
- **Timer trap, direct vector.** mstatus=0x8, mie=0x80, mtvec=0x8000_0000, pc=0x1000, `tmr_irq_i`=1.
  - Writes: mepc=0x1000, then mcause=0x8000_0000_0000_0007, then mstatus=0x1880.
  - Then jump to 0x8000_0000 at N+4.
- **Vectored external interrupt with simultaneous ecall.** mtvec=0x8000_0001, ext and sft both pending, `ecall_i`=1.
  - Cause 11 with the interrupt bit set; target 0x8000_002C.
- **ecall with MIE=0 and an interrupt pending.** mstatus=0x0, `tmr_irq_i`=1, `ecall_i`=1, pc=0x2000.
  - mcause=11, mepc=0x2000, mstatus=0x1800, target = mtvec base.
- **mret.** mstatus=0x1880, mepc=0x3004, `mret_i`=1.
  - mstatus write 0x1888 at N+1; jump to 0x3004 at N+2; `hold_o` high for cycles N through N+2.
- **Reset mid-sequence.** `rst_n`=0 in the W_MCAUSE cycle.
  - No mstatus write and no jump; all outputs 0 from the next cycle; state IDLE.
